keyb_emul: RTL
==============

# keyb_emul

Synthesizable matrix-keypad emulator: the key side of the 4x4 row/column scan interface. Accepts key codes (digits, `+`, `-`, `=`) over a valid/ready handshake, buffers them in a small FIFO, and "presses" each key by driving `rows` in response to the scanner's column drive. Each press lasts a programmed hold time with optional contact bounce, followed by a release gap. Used for on-board self-test of the scanner and calculator, and as the stimulus end of scanner benches.

## Interface
- `HOLD_CYCLES`, 60000: cycles a key stays pressed (must exceed scanner debounce + sync); ≥2.
- `GAP_CYCLES`, 60000: cycles of full release between presses; ≥1.
- `BOUNCE_CYCLES`, 0: initial part of the hold during which contact bounces; 0 = clean press; < `HOLD_CYCLES`.
- `BOUNCE_PERIOD`, 16: contact toggles every `BOUNCE_PERIOD` cycles while bouncing; ≥1.
- `FIFO_DEPTH`, 4: key queue depth, power of 2, ≥2.
- `clk`  in  1  single clock, all flops rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `cols`  in  4  one-hot column drive from the scanner.
- `rows`  out  4  row lines; bit r high when the pressed key is in row r and its column is driven.
- `key_valid`  in  1  key code offered.
- `key_code`  in  4  0–9 digits, 10 `+`, 11 `-`, 12 `=`; 13–15 invalid.
- `key_ready`  out  1  FIFO not full.
- `key_invalid`  out  1  1-cycle pulse: accepted code was 13–15 and dropped.
- `key_done`  out  1  1-cycle pulse at end of each hold.
- `busy`  out  1  FSM not IDLE or FIFO non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH+1)  keys queued.

## Operation
- Key map (code → column, row), column = `cols` bit index, row = `rows` bit index: 1→(0,0) 2→(1,0) 3→(2,0) 4→(0,1) 5→(1,1) 6→(2,1) 7→(0,2) 8→(1,2) 9→(2,2) 0→(1,3) `+`→(3,0) `-`→(3,1) `=`→(3,3).
- Handshake: transfer when `key_valid && key_ready` at a clock edge. Valid code is written to FIFO; invalid code is consumed, not written, `key_invalid` pulses next cycle. `key_valid` without ready: no effect, producer holds.
- FIFO stores translated {col,row} (4 bits). Push and pop in the same cycle allowed (count unchanged). No bypass.
- FSM states: IDLE, PRESS, RELEASE.
  - IDLE: FIFO non-empty → pop into `col_sel`/`row_sel`, load counter, go PRESS.
  - PRESS: exactly `HOLD_CYCLES` cycles. Contact closed except during the first `BOUNCE_CYCLES` cycles, where contact starts closed and inverts every `BOUNCE_PERIOD` cycles. Last PRESS cycle: `key_done` pulses next cycle, go RELEASE.
  - RELEASE: exactly `GAP_CYCLES` cycles, contact open, then IDLE.
- `rows` is combinational: `rows = (contact && cols[col_sel]) ? onehot(row_sel) : 4'b0000`. Non-one-hot `cols` is not checked; only bit `col_sel` matters.
- Only one key pressed at a time; never two rows high.

## Timing
- Reset values: `rows`=0, `key_ready`=1, `key_invalid`=0, `key_done`=0, `busy`=0, `fifo_count`=0; FSM IDLE, FIFO empty.
- Reset asserted mid-press: `rows` drops to 0 asynchronously; queued keys are discarded.
- Latency: key accepted at edge T into an empty FIFO with FSM IDLE → popped at edge T+1 → contact active from T+1 through T+HOLD_CYCLES; `key_done` high in cycle after edge T+HOLD_CYCLES.
- Back-to-back keys: next PRESS begins exactly `HOLD_CYCLES+GAP_CYCLES+1` cycles after the previous one (1 IDLE cycle).
- Full: `key_ready`=0 when `fifo_count`=FIFO_DEPTH; deasserts in the cycle after the filling push and reasserts the cycle after a pop.
- `rows` responds to `cols` in the same cycle (zero register latency).

## Test plan
- HOLD=8, GAP=4: push code 5, `cols` rotating 0001→1000 each cycle → `rows`=0010 only when `cols`=0010, for 8 cycles from T+1; `key_done` once; `busy` falls after GAP+1 cycles.
- Push 12 then 10 → `rows`=1000 on `cols`=1000 for 8 cycles, 4-cycle gap + 1 IDLE, then `rows`=0001 on `cols`=1000; with the real scanner attached it reports `is_eq` then `is_op`/`op_val`=1.
- Push 14 → `key_invalid` pulse, `fifo_count` stays 0, `rows` stays 0.
- Push 5 keys with DEPTH=4 while first is in PRESS → `key_ready` low once count reaches 4; fifth held until a pop; all 5 pressed in order.
- BOUNCE_CYCLES=6, BOUNCE_PERIOD=2, `cols` held at key column → contact 1,1,0,0,1,1 then solid 1 for remaining 2 hold cycles.
- Assert `reset` mid-PRESS with 2 keys queued → `rows`=0 immediately, `fifo_count`=0, `key_done` never pulses; after release, new key presses normally.

Source files
------------

// File: rtl/keyb_emul_if.sv
// ---------------------------------------------------------------------------
// keyb_emul_if
// Key-code handshake between a producer (self-test sequencer or bench) and
// the keypad emulator.
//   key_valid  producer -> emulator  key code offered
//   key_code   producer -> emulator  0-9 digits, 10 '+', 11 '-', 12 '='
//   key_ready  emulator -> producer  key queue has room
// A transfer happens on a rising clock edge with key_valid && key_ready.
// ---------------------------------------------------------------------------
interface keyb_emul_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;

    modport master (output key_valid, output key_code, input key_ready);
    modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/keyb_emul.sv
// ---------------------------------------------------------------------------
// keyb_emul
// Key side of a 4x4 row/column keypad scan interface. Key codes arrive over
// key_bus, are translated to {column,row} and queued in a small FIFO, then
// "pressed" one at a time: for HOLD_CYCLES the selected row follows the
// scanner's drive on the selected column (with optional contact bounce at the
// start), followed by GAP_CYCLES of full release.
//
// Ports
//   clk         single clock, rising edge
//   reset       asynchronous, active-high, clears all state
//   key_bus     slave side of the key-code handshake
//   cols        column drive from the scanner (only bit col_sel matters)
//   rows        row lines, combinational from cols
//   key_invalid 1-cycle pulse: accepted code was 13-15 and dropped
//   key_done    1-cycle pulse after the last hold cycle of each key
//   busy        a key is in progress or queued
//   fifo_count  number of keys queued
// ---------------------------------------------------------------------------
module keyb_emul #(
    parameter int HOLD_CYCLES   = 60000,
    parameter int GAP_CYCLES    = 60000,
    parameter int BOUNCE_CYCLES = 0,
    parameter int BOUNCE_PERIOD = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    keyb_emul_if.slave                      key_bus,
    input  logic [3:0]                      cols,
    output logic [3:0]                      rows,
    output logic                            key_invalid,
    output logic                            key_done,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

    typedef enum logic [1:0] {IDLE, PRESS, RELEASE} state_t;

    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int MAX_PHASE = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int PH_W      = $clog2(MAX_PHASE);
    localparam int PER_W     = (BOUNCE_PERIOD > 1) ? $clog2(BOUNCE_PERIOD) : 1;

    localparam logic [CNT_W-1:0] FULL        = CNT_W'(FIFO_DEPTH);
    localparam logic [PH_W-1:0]  HOLD_LAST   = PH_W'(HOLD_CYCLES - 1);
    localparam logic [PH_W-1:0]  GAP_LAST    = PH_W'(GAP_CYCLES - 1);
    localparam logic [PH_W-1:0]  BOUNCE_LAST = PH_W'(BOUNCE_CYCLES - 1);
    localparam logic [PER_W-1:0] PER_LAST    = PER_W'(BOUNCE_PERIOD - 1);

    // Translate a key code to {column, row}; codes 13-15 never reach the FIFO.
    function automatic logic [3:0] key_map(input logic [3:0] code);
        case (code)
            4'd1:    key_map = {2'd0, 2'd0};
            4'd2:    key_map = {2'd1, 2'd0};
            4'd3:    key_map = {2'd2, 2'd0};
            4'd4:    key_map = {2'd0, 2'd1};
            4'd5:    key_map = {2'd1, 2'd1};
            4'd6:    key_map = {2'd2, 2'd1};
            4'd7:    key_map = {2'd0, 2'd2};
            4'd8:    key_map = {2'd1, 2'd2};
            4'd9:    key_map = {2'd2, 2'd2};
            4'd0:    key_map = {2'd1, 2'd3};
            4'd10:   key_map = {2'd3, 2'd0};
            4'd11:   key_map = {2'd3, 2'd1};
            4'd12:   key_map = {2'd3, 2'd3};
            default: key_map = 4'd0;
        endcase
    endfunction

    state_t           state;
    logic [3:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [1:0]       col_sel, row_sel;
    logic [PH_W-1:0]  ph_cnt;      // cycles elapsed in the current PRESS/RELEASE
    logic [PER_W-1:0] per_cnt;     // position inside one bounce half-period
    logic             level;       // bounce contact level, starts closed
    logic             bouncing;    // still inside the bounce window
    logic             contact;
    logic             code_ok, accept, push, pop;

    assign key_bus.key_ready = (fifo_count != FULL);
    assign code_ok = (key_bus.key_code <= 4'd12);
    assign accept  = key_bus.key_valid && key_bus.key_ready;
    assign push    = accept && code_ok;
    assign pop     = (state == IDLE) && (fifo_count != '0);
    assign busy    = (state != IDLE) || (fifo_count != '0);
    assign contact = (state == PRESS) && (!bouncing || level);

    // NOTE: every output of an always_comb gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        rows = 4'b0000;
        if (contact && cols[col_sel]) begin
            rows[row_sel] = 1'b1;
        end
    end

    // NOTE: the queue storage has no reset; only pointers and count define
    // which entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= key_map(key_bus.key_code);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rd_ptr      <= '0;
            col_sel     <= 2'd0;
            row_sel     <= 2'd0;
            ph_cnt      <= '0;
            per_cnt     <= '0;
            level       <= 1'b0;
            bouncing    <= 1'b0;
            key_done    <= 1'b0;
            key_invalid <= 1'b0;
        end else begin
            key_done    <= 1'b0;
            key_invalid <= accept && !code_ok;
            case (state)
                IDLE: begin
                    if (pop) begin
                        {col_sel, row_sel} <= mem[rd_ptr];
                        rd_ptr   <= rd_ptr + PTR_W'(1);
                        ph_cnt   <= '0;
                        per_cnt  <= '0;
                        level    <= 1'b1;
                        bouncing <= (BOUNCE_CYCLES != 0);
                        state    <= PRESS;
                    end
                end
                PRESS: begin
                    // Bounce timing: level inverts after every BOUNCE_PERIOD cycles.
                    if (per_cnt == PER_LAST) begin
                        per_cnt <= '0;
                        level   <= ~level;
                    end else begin
                        per_cnt <= per_cnt + PER_W'(1);
                    end
                    if (ph_cnt == BOUNCE_LAST) begin
                        bouncing <= 1'b0;
                    end
                    if (ph_cnt == HOLD_LAST) begin
                        ph_cnt   <= '0;
                        key_done <= 1'b1;
                        state    <= RELEASE;
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
                RELEASE: begin
                    if (ph_cnt == GAP_LAST) begin
                        ph_cnt <= '0;
                        state  <= IDLE;
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
